// File: rtl/drv_slot_scheduler_if.sv
// Control/status bundle between the frame source side and the slot scheduler.
interface drv_slot_scheduler_if;
  logic       enable;
  logic       sync_in;
  logic       blanking;
  logic       data_req;
  logic [3:0] bit_plane;
  logic [5:0] chan_idx;
  logic       wrtgs;
  logic       latgs;
  logic [2:0] mux_sel;
  logic       running;
  logic [7:0] err_count;

  modport master (
    output enable, sync_in,
    input  blanking, data_req, bit_plane, chan_idx, wrtgs, latgs,
           mux_sel, running, err_count
  );

  modport slave (
    input  enable, sync_in,
    output blanking, data_req, bit_plane, chan_idx, wrtgs, latgs,
           mux_sel, running, err_count
  );
endinterface

// File: rtl/drv_slot_scheduler.sv
// Multiplex-slot timing controller: locks to frame sync, sequences blanking,
// bit-plane groups, GS write/latch strobes and column select; counts sync faults.
module drv_slot_scheduler #(
  parameter int POKER_MODE      = 9,
  parameter int BLANKING_CYCLES = 72,
  parameter int GROUP_CYCLES    = 48,
  parameter int MUX_COUNT       = 8,
  parameter int SLOT_CYCLES     = 513
) (
  input logic                  clk_33,
  input logic                  nrst,
  drv_slot_scheduler_if.slave  bus
);

  if (SLOT_CYCLES != BLANKING_CYCLES + POKER_MODE * (GROUP_CYCLES + 1)) begin : g_bad_slot
    $error("SLOT_CYCLES inconsistent with blanking and group timing");
  end

  localparam logic [9:0] BLANK_END  = 10'(BLANKING_CYCLES);
  localparam logic [9:0] SLOT_LAST  = 10'(SLOT_CYCLES - 1);
  localparam logic [5:0] GRP_LASTD  = 6'(GROUP_CYCLES - 1);
  localparam logic [5:0] GRP_GAP    = 6'(GROUP_CYCLES);
  localparam logic [3:0] PLANE_LAST = 4'(POKER_MODE - 1);
  localparam logic [2:0] MUX_LAST   = 3'(MUX_COUNT - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e     state_q, state_d;
  logic [9:0] slot_q, slot_d;
  logic [5:0] grp_q, grp_d;
  logic [3:0] plane_q, plane_d;
  logic [2:0] mux_q, mux_d;
  logic [7:0] err_q, err_d;

  logic run, active, slot_end, sync_expected;

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      grp_q   <= '0;
      plane_q <= '0;
      mux_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      grp_q   <= grp_d;
      plane_q <= plane_d;
      mux_q   <= mux_d;
      err_q   <= err_d;
    end
  end

  assign slot_end      = (slot_q == SLOT_LAST);
  assign sync_expected = slot_end && (mux_q == MUX_LAST);

  always_comb begin
    state_d = state_q;
    slot_d  = '0;
    grp_d   = '0;
    plane_d = '0;
    mux_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && bus.sync_in) state_d = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (bus.sync_in && !sync_expected) begin
          // Mis-timed sync: realign to slot 0 of mux 0 (counters stay at default 0).
          if (err_q != '1) err_d = err_q + 8'd1;
        end else if (slot_end) begin
          mux_d = (mux_q == MUX_LAST) ? '0 : mux_q + 3'd1;
          if (mux_q == MUX_LAST && !bus.sync_in && err_q != '1) err_d = err_q + 8'd1;
        end else begin
          slot_d  = slot_q + 10'd1;
          mux_d   = mux_q;
          grp_d   = grp_q;
          plane_d = plane_q;
          if (slot_q >= BLANK_END) begin
            if (grp_q == GRP_GAP) begin
              grp_d   = '0;
              plane_d = plane_q + 4'd1;
            end else begin
              grp_d = grp_q + 6'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run    = (state_q == RUN);
  assign active = run && (slot_q >= BLANK_END);

  assign bus.running   = run;
  assign bus.blanking  = !active;
  assign bus.data_req  = active && (grp_q < GRP_GAP);
  assign bus.chan_idx  = (active && grp_q < GRP_GAP) ? grp_q : '0;
  assign bus.bit_plane = run ? plane_q : '0;
  assign bus.mux_sel   = run ? mux_q : '0;
  assign bus.wrtgs     = active && (grp_q == GRP_LASTD) && (plane_q < PLANE_LAST);
  assign bus.latgs     = active && (grp_q == GRP_LASTD) && (plane_q >= PLANE_LAST);
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_drv_slot_scheduler.sv
// Directed bench for drv_slot_scheduler with hand-computed slot timing.
module tb_drv_slot_scheduler;
  logic clk_33 = 1'b0;
  logic nrst   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  drv_slot_scheduler_if bus ();

  drv_slot_scheduler #(
    .POKER_MODE(9), .BLANKING_CYCLES(72), .GROUP_CYCLES(48),
    .MUX_COUNT(8), .SLOT_CYCLES(513)
  ) dut (
    .clk_33(clk_33),
    .nrst  (nrst),
    .bus   (bus)
  );

  always #15 clk_33 = ~clk_33;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_33);
    #1;
  endtask

  initial begin
    int wr_cnt, lat_cnt, mux_bad;
    bus.enable  = 1'b0;
    bus.sync_in = 1'b0;
    wr_cnt = 0; lat_cnt = 0; mux_bad = 0;

    step(3);
    chk("rst_blanking", bus.blanking, 1);
    chk("rst_running", bus.running, 0);
    chk("rst_data_req", bus.data_req, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_mux", bus.mux_sel, 0);
    nrst = 1'b1;

    bus.enable = 1'b1;
    step(2000);
    chk("nosync_running", bus.running, 0);
    chk("nosync_blanking", bus.blanking, 1);
    chk("nosync_data_req", bus.data_req, 0);
    chk("nosync_err", bus.err_count, 0);

    // sync at T; now at T+1
    bus.sync_in = 1'b1; step(1); bus.sync_in = 1'b0;
    chk("t1_running", bus.running, 1);
    chk("t1_blanking", bus.blanking, 1);
    chk("t1_data_req", bus.data_req, 0);
    step(71);
    chk("t72_blanking", bus.blanking, 1);
    chk("t72_data_req", bus.data_req, 0);
    step(1);
    chk("t73_data_req", bus.data_req, 1);
    chk("t73_bit_plane", bus.bit_plane, 0);
    chk("t73_chan", bus.chan_idx, 0);
    chk("t73_blanking", bus.blanking, 0);
    step(47);
    chk("t120_wrtgs", bus.wrtgs, 1);
    chk("t120_latgs", bus.latgs, 0);
    chk("t120_chan", bus.chan_idx, 47);
    step(1);
    chk("t121_data_req", bus.data_req, 0);
    chk("t121_chan", bus.chan_idx, 0);
    chk("t121_wrtgs", bus.wrtgs, 0);
    step(1);
    chk("t122_bit_plane", bus.bit_plane, 1);
    step(390);
    chk("t512_latgs", bus.latgs, 1);
    chk("t512_wrtgs", bus.wrtgs, 0);
    chk("t512_bit_plane", bus.bit_plane, 8);
    step(1);
    chk("t513_data_req", bus.data_req, 0);
    chk("t513_latgs", bus.latgs, 0);
    chk("t513_blanking", bus.blanking, 0);
    step(1);
    chk("t514_blanking", bus.blanking, 1);
    chk("t514_mux", bus.mux_sel, 1);

    // on-schedule syncs at T+4104*k; strobes counted over frames 2..4
    for (int t = 514; t <= 16416; t++) begin
      bus.sync_in = ((t % 4104) == 0);
      if (t >= 4105) begin
        if (bus.wrtgs) wr_cnt++;
        if (bus.latgs) lat_cnt++;
      end
      if (bus.mux_sel !== 3'(((t - 1) % 4104) / 513)) mux_bad++;
      step(1);
    end
    bus.sync_in = 1'b0;
    chk("frames_wrtgs", wr_cnt, 192);
    chk("frames_latgs", lat_cnt, 24);
    chk("frames_mux_seq_bad", mux_bad, 0);
    chk("frames_err", bus.err_count, 0);
    chk("frames_mux0", bus.mux_sel, 0);
    chk("frames_blanking", bus.blanking, 1);

    step(1739);
    chk("early_pre_mux", bus.mux_sel, 3);
    chk("early_pre_data", bus.data_req, 1);
    bus.sync_in = 1'b1; step(1); bus.sync_in = 1'b0;
    chk("early_mux", bus.mux_sel, 0);
    chk("early_blanking", bus.blanking, 1);
    chk("early_err", bus.err_count, 1);
    chk("early_running", bus.running, 1);
    step(72);
    chk("early_slot72_data", bus.data_req, 1);
    chk("early_slot72_chan", bus.chan_idx, 0);

    step(4031);
    chk("miss_pre_mux", bus.mux_sel, 7);
    chk("miss_pre_err", bus.err_count, 1);
    step(1);
    chk("miss_mux", bus.mux_sel, 0);
    chk("miss_err", bus.err_count, 2);
    chk("miss_blanking", bus.blanking, 1);
    chk("miss_running", bus.running, 1);

    for (int i = 0; i < 300; i++) begin
      bus.sync_in = 1'b1; step(1); bus.sync_in = 1'b0; step(1);
    end
    chk("sat_err", bus.err_count, 255);
    step(80);
    chk("sat_err_hold", bus.err_count, 255);
    chk("drop_pre_data", bus.data_req, 1);

    bus.enable = 1'b0; bus.sync_in = 1'b1; step(1); bus.sync_in = 1'b0;
    chk("drop_running", bus.running, 0);
    chk("drop_data_req", bus.data_req, 0);
    chk("drop_blanking", bus.blanking, 1);
    chk("drop_err_hold", bus.err_count, 255);
    bus.enable = 1'b1; step(10);
    chk("reen_nosync_running", bus.running, 0);

    bus.sync_in = 1'b1; step(1); bus.sync_in = 1'b0;
    step(100);
    chk("resync_data", bus.data_req, 1);
    nrst = 1'b0;
    #2;
    chk("arst_err", bus.err_count, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_blanking", bus.blanking, 1);
    chk("arst_data_req", bus.data_req, 0);
    chk("arst_chan", bus.chan_idx, 0);
    nrst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
